mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  MEM pipeline stage for a data memory with variable latency (SRAM-like req/addr_ok/data_ok).
//  Holds one EX->MEM instruction and waits for its data_ok. Buffers the returned word while WB stalls.
//  Aligns and extends load data: lb/lbu/lh/lhu/lw/lwl/lwr. Forwards results to ID.
//  Discards stale responses after a pipeline flush. Sits between EX and WB.
// PARAMETERS
//  ES_TO_MS_BUS_WD  124  EX->MEM bus: {need_data[123], ld_op[122:120], rt_value[119:88], rsvd[87:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
//  MS_TO_WS_BUS_WD  74   MEM->WB bus: {byte_we[73:70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
//  MAX_OUTSTANDING  2    max in-flight responses to drop after a flush; sets discard counter width clog2(N+1)
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  reset           in   1   synchronous, active-high
//  ws_allowin      in   1   WB can accept this cycle
//  ms_allowin      out  1   MEM can accept this cycle
//  es_to_ms_valid  in   1   EX offers an instruction
//  es_to_ms_bus    in   ES_TO_MS_BUS_WD  EX payload
//  es_req_fire     in   1   EX's data request handshake completed this cycle (req & addr_ok)
//  ms_to_ws_valid  out  1   MEM offers an instruction to WB
//  ms_to_ws_bus    out  MS_TO_WS_BUS_WD  WB payload; all-zero when ms_to_ws_valid=0
//  ms_fwd_bus      out  40  {blk[39], we[38], dest[37:33], result[32:1], valid[0]} to ID for bypass and stall
//  flush           in   1   exception/eret from WB; kill the MEM contents
//  data_sram_data_ok in 1   response strobe
//  data_sram_rdata in   32  response data, valid when data_ok=1
// BEHAVIOUR
//  Reset: ms_valid=0, buf_valid=0, discard_cnt=0, inflight=0; all outputs 0, except ms_allowin=1.
//  Capture: on es_to_ms_valid & ms_allowin, bus_r <= es_to_ms_bus (non-blocking). ms_valid <= es_to_ms_valid while ms_allowin=1.
//  inflight: +1 on es_req_fire; -1 on data_ok; both in one cycle = no change. Must never exceed MAX_OUTSTANDING.
//  Response ownership: a data_ok with discard_cnt>0 is stale. discard_cnt decrements; buf and data are untouched.
//   Otherwise the response belongs to the MEM instruction (need_data=1).
//  ready: ms_ready_go = !need_data | buf_valid | (own data_ok this cycle). Zero-latency data_ok passes through combinationally.
//  Buffer: an own data_ok with ws_allowin=0 loads buf_data<=rdata and sets buf_valid=1.
//   buf_valid clears when MEM hands off to WB, or on flush.
//  Handshake: ms_to_ws_valid = ms_valid & ready_go & !flush.
//   ms_allowin = !ms_valid | (ready_go & ws_allowin).
//  Flush: ms_valid<=0 and buf_valid<=0 next cycle.
//   If flush occurs with ms_valid & need_data & !buf_valid and no own data_ok that cycle, discard_cnt <= inflight.
//   The same applies to requests of EX instructions killed by the flush: discard_cnt <= inflight_after_update.
//   Flush takes priority over capture.
//  Load data (off=alu_result[1:0], w=selected rdata/buf_data), by ld_op:
//   0 lw:  w
//   1 lb:  sext(byte off)
//   2 lbu: zext(byte off)
//   3 lh:  sext(w[16*off[1]+:16])
//   4 lhu: zext(w[16*off[1]+:16])
//   5 lwl: off0 {w[7:0],rt[23:0]}, off1 {w[15:0],rt[15:0]}, off2 {w[23:0],rt[7:0]}, off3 w
//   6 lwr: off0 w, off1 {rt[31:24],w[31:8]}, off2 {rt[31:16],w[31:16]}, off3 {rt[31:8],w[31:24]}
//   7: reserved, treated as lw
//   Odd-offset lh/lhu never arrives; AdEL is raised in EX.
//  final_result = res_from_mem ? load_data : alu_result.
//  byte_we:
//   lwl off k: 4'b1111<<(3-k)
//   lwr off k: 4'b1111>>k
//   otherwise: {4{gr_we}}
//  Forwarding: valid=ms_valid, we=gr_we, dest, result=final_result.
//   blk=ms_valid & res_from_mem & !ready_go, so ID stalls on an unresolved load.
// STRUCTURE
//  Shared mycpu.h: bus widths, bit offsets, LD_* op encodings (3'd0..3'd6).
//  One sub-module: mem_load_align (pure combinational: off, ld_op, word, rt -> result, byte_we).
//  Handshake, buffer and discard counter stay in the top module.
// TESTING
//  lw with 0-latency data_ok, ws_allowin=1, rdata=32'h8899AABB -> same cycle ms_to_ws_valid=1, result 32'h8899AABB.
//  lb off=3 rdata=32'h80112233 -> 32'hFFFFFF80; lbu -> 32'h00000080; lhu off=2 -> 32'h00008011.
//  lwl off=1 rt=32'h11223344 rdata=32'hAABBCCDD -> 32'hCCDD3344, byte_we 4'b1100; lwr off=2 -> 32'h1122AABB, byte_we 4'b0011.
//  data_ok while ws_allowin=0 for 3 cycles, then 1 -> buf holds word, no loss, ms_allowin=0 until handoff.
//  flush with 2 in flight -> discard_cnt=2; next two data_ok dropped; a new load then gets its own data.
//  Load waiting 4 cycles -> ms_fwd blk=1 for those cycles, 0 on the data_ok cycle; reset mid-wait -> all state 0.

Source files
------------

// File: rtl/mem_stage_hs_pkg.sv
// mem_stage_hs_pkg: bus layouts and load-op encodings shared by the MEM stage.
package mem_stage_hs_pkg;
  localparam int ES_TO_MS_WD = 124;
  localparam int MS_TO_WS_WD = 74;
  localparam int MS_FWD_WD = 40;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4,
    LD_WL = 3'd5,
    LD_WR = 3'd6
  } ld_op_e;
  typedef struct packed {
    logic        need_data;
    logic [2:0]  ld_op;
    logic [31:0] rt_value;
    logic [16:0] rsvd;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;
  typedef struct packed {
    logic [3:0]  byte_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;
  typedef struct packed {
    logic        blk;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        valid;
  } ms_fwd_t;
endpackage

// File: rtl/mem_stage_hs_load_align.sv
// mem_load_align: aligns/extends returned load data and derives the register byte enables.
module mem_load_align
  import mem_stage_hs_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_ld_op,
  input  logic        i_is_load,
  input  logic        i_gr_we,
  input  logic [31:0] i_word,
  input  logic [31:0] i_rt,
  output logic [31:0] o_result,
  output logic [3:0]  o_byte_we
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;
  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  assign w_lwl = i_off == 2'd0 ? {i_word[7:0], i_rt[23:0]} :
                 i_off == 2'd1 ? {i_word[15:0], i_rt[15:0]} :
                 i_off == 2'd2 ? {i_word[23:0], i_rt[7:0]} : i_word;
  assign w_lwr = i_off == 2'd0 ? i_word :
                 i_off == 2'd1 ? {i_rt[31:24], i_word[31:8]} :
                 i_off == 2'd2 ? {i_rt[31:16], i_word[31:16]} : {i_rt[31:8], i_word[31:24]};
  assign o_result = i_ld_op == LD_B  ? {{24{w_byte[7]}}, w_byte} :
                    i_ld_op == LD_BU ? {24'd0, w_byte} :
                    i_ld_op == LD_H  ? {{16{w_half[15]}}, w_half} :
                    i_ld_op == LD_HU ? {16'd0, w_half} :
                    i_ld_op == LD_WL ? w_lwl :
                    i_ld_op == LD_WR ? w_lwr : i_word;
  assign o_byte_we = i_is_load && i_ld_op == LD_WL ? 4'b1111 << (2'd3 - i_off) :
                     i_is_load && i_ld_op == LD_WR ? 4'b1111 >> i_off : {4{i_gr_we}};
endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM stage with variable-latency data response, WB-stall buffer and post-flush discard.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int ES_TO_MS_BUS_WD = 124,
  parameter int MS_TO_WS_BUS_WD = 74,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       es_req_fire,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [39:0]                ms_fwd_bus,
  input  logic                       flush,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic                       r_valid;
  logic                       r_buf_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic [31:0]                r_buf_data;
  logic [CW-1:0]              r_inflight;
  logic [CW-1:0]              r_discard_cnt;
  es_to_ms_t                  w_es;
  ms_to_ws_t                  w_ws;
  ms_fwd_t                    w_fwd;
  logic                       w_stale;
  logic                       w_own_ok;
  logic                       w_ready_go;
  logic                       w_handoff;
  logic [CW-1:0]              w_inflight_nx;
  logic [31:0]                w_word;
  logic [31:0]                w_load;
  logic [31:0]                w_final;
  logic [3:0]                 w_byte_we;
  assign w_es = r_bus;
  // Responses arrive in request order, so anything still owed when a flush hits is stale.
  assign w_stale = data_sram_data_ok && r_discard_cnt != '0;
  assign w_own_ok = data_sram_data_ok && !w_stale && r_valid && w_es.need_data && !r_buf_valid;
  assign w_ready_go = !w_es.need_data || r_buf_valid || w_own_ok;
  assign ms_to_ws_valid = r_valid && w_ready_go && !flush;
  assign ms_allowin = !r_valid || (w_ready_go && ws_allowin);
  assign w_handoff = ms_to_ws_valid && ws_allowin;
  assign w_inflight_nx = r_inflight + CW'(es_req_fire) - CW'(data_sram_data_ok);
  assign w_word = r_buf_valid ? r_buf_data : data_sram_rdata;
  mem_load_align u_align (
    .i_off     (w_es.alu_result[1:0]),
    .i_ld_op   (w_es.ld_op),
    .i_is_load (w_es.res_from_mem),
    .i_gr_we   (w_es.gr_we),
    .i_word    (w_word),
    .i_rt      (w_es.rt_value),
    .o_result  (w_load),
    .o_byte_we (w_byte_we)
  );
  assign w_final = w_es.res_from_mem ? w_load : w_es.alu_result;
  assign w_ws = '{byte_we: w_byte_we, gr_we: w_es.gr_we, dest: w_es.dest,
                  final_result: w_final, pc: w_es.pc};
  assign w_fwd = '{blk: w_es.res_from_mem && !w_ready_go, we: w_es.gr_we, dest: w_es.dest,
                   result: w_final, valid: 1'b1};
  assign ms_to_ws_bus = ms_to_ws_valid ? w_ws : '0;
  assign ms_fwd_bus = r_valid ? w_fwd : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_bus         <= '0;
      r_buf_data    <= '0;
      r_inflight    <= '0;
      r_discard_cnt <= '0;
    end else begin
      r_inflight <= w_inflight_nx;
      if (flush) begin
        r_valid       <= 1'b0;
        r_buf_valid   <= 1'b0;
        r_discard_cnt <= w_inflight_nx;
      end else begin
        if (w_stale) r_discard_cnt <= r_discard_cnt - CW'(1);
        if (ms_allowin) r_valid <= es_to_ms_valid;
        if (ms_allowin && es_to_ms_valid) r_bus <= es_to_ms_bus;
        if (w_handoff) r_buf_valid <= 1'b0;
        else if (w_own_ok && !ws_allowin) begin
          r_buf_valid <= 1'b1;
          r_buf_data  <= data_sram_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed checks of load alignment, WB stall buffering, flush discard and forwarding.
module tb_mem_stage_hs;
  import mem_stage_hs_pkg::*;
  logic         clk = 1'b0;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [123:0] es_to_ms_bus;
  logic         es_req_fire;
  logic         ms_to_ws_valid;
  logic [73:0]  ms_to_ws_bus;
  logic [39:0]  ms_fwd_bus;
  logic         flush;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mem_stage_hs dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .es_req_fire       (es_req_fire),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_fwd_bus        (ms_fwd_bus),
    .flush             (flush),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [123:0] mk(input logic need, input logic [2:0] op, input logic [31:0] rt,
                                      input logic res, input logic we, input logic [4:0] dest,
                                      input logic [31:0] alu, input logic [31:0] pc);
    return {need, op, rt, 17'd0, res, we, dest, alu, pc};
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #4;
  endtask
  task automatic ld_test(input string tag, input logic [2:0] op, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] rd,
                         input logic [31:0] exp_res, input logic [3:0] exp_we);
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, op, rt, 1'b1, 1'b1, 5'd4, alu, 32'hbfc0_0100);
    es_req_fire = 1'b1;
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = rd;
    settle;
    check({tag, "_vld"}, 64'(ms_to_ws_valid), 64'd1);
    check({tag, "_res"}, 64'(ms_to_ws_bus[63:32]), 64'(exp_res));
    check({tag, "_we"}, 64'(ms_to_ws_bus[73:70]), 64'(exp_we));
    cyc;
    data_sram_data_ok = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    es_req_fire = 1'b0;
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    cyc;
    cyc;
    reset = 1'b0;
    settle;
    check("rst_allowin", 64'(ms_allowin), 64'd1);
    check("rst_valid", 64'(ms_to_ws_valid), 64'd0);
    check("rst_bus", 64'(ms_to_ws_bus[63:0]), 64'd0);
    check("rst_fwd", 64'(ms_fwd_bus), 64'd0);
    ld_test("lw", LD_W, 32'h100, 32'h0, 32'h8899AABB, 32'h8899AABB, 4'b1111);
    ld_test("lb", LD_B, 32'h103, 32'h0, 32'h80112233, 32'hFFFFFF80, 4'b1111);
    ld_test("lbu", LD_BU, 32'h103, 32'h0, 32'h80112233, 32'h00000080, 4'b1111);
    ld_test("lhu", LD_HU, 32'h102, 32'h0, 32'h80112233, 32'h00008011, 4'b1111);
    ld_test("lh", LD_H, 32'h102, 32'h0, 32'h80112233, 32'hFFFF8011, 4'b1111);
    ld_test("lwl", LD_WL, 32'h101, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344, 4'b1100);
    ld_test("lwr", LD_WR, 32'h102, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB, 4'b0011);
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b0, LD_W, 32'h0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h2000);
    cyc;
    es_to_ms_valid = 1'b0;
    settle;
    check("alu_vld", 64'(ms_to_ws_valid), 64'd1);
    check("alu_res", 64'(ms_to_ws_bus[63:32]), 64'h1234);
    check("alu_we", 64'(ms_to_ws_bus[73:70]), 64'hF);
    check("alu_fwd", 64'(ms_fwd_bus), {24'd0, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b1});
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd6, 32'h200, 32'h3000);
    es_req_fire = 1'b1;
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEF00D;
    settle;
    check("buf_ok_allowin", 64'(ms_allowin), 64'd0);
    check("buf_ok_vld", 64'(ms_to_ws_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      cyc;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      settle;
      check("buf_hold_res", 64'(ms_to_ws_bus[63:32]), 64'hCAFEF00D);
      check("buf_hold_allowin", 64'(ms_allowin), 64'd0);
    end
    cyc;
    ws_allowin = 1'b1;
    settle;
    check("buf_go_allowin", 64'(ms_allowin), 64'd1);
    check("buf_go_res", 64'(ms_to_ws_bus[63:32]), 64'hCAFEF00D);
    cyc;
    settle;
    check("buf_done_vld", 64'(ms_to_ws_valid), 64'd0);
    check("buf_done_bv", 64'(dut.r_buf_valid), 64'd0);
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd8, 32'h20, 32'h4000);
    es_req_fire = 1'b1;
    cyc;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd10, 32'h24, 32'h4004);
    settle;
    check("fl_wait_allowin", 64'(ms_allowin), 64'd0);
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    flush = 1'b1;
    settle;
    check("fl_vld", 64'(ms_to_ws_valid), 64'd0);
    cyc;
    flush = 1'b0;
    settle;
    check("fl_discard", 64'(dut.r_discard_cnt), 64'd2);
    check("fl_allowin", 64'(ms_allowin), 64'd1);
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd9, 32'h40, 32'h5000);
    es_req_fire = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD0001;
    settle;
    check("stale1_vld", 64'(ms_to_ws_valid), 64'd0);
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    data_sram_rdata = 32'hDEAD0002;
    settle;
    check("stale2_vld", 64'(ms_to_ws_valid), 64'd0);
    check("stale2_blk", 64'(ms_fwd_bus[39]), 64'd1);
    cyc;
    data_sram_rdata = 32'h600D600D;
    settle;
    check("own_vld", 64'(ms_to_ws_valid), 64'd1);
    check("own_res", 64'(ms_to_ws_bus[63:32]), 64'h600D600D);
    cyc;
    data_sram_data_ok = 1'b0;
    settle;
    check("own_inflight", 64'(dut.r_inflight), 64'd0);
    check("own_discard", 64'(dut.r_discard_cnt), 64'd0);
    cyc;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd7, 32'h44, 32'h6000);
    es_req_fire = 1'b1;
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle;
      check("fwd_wait", 64'(ms_fwd_bus[39:33] & 7'h7F), {57'd0, 1'b1, 1'b1, 5'd7});
      cyc;
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h12345678;
    settle;
    check("fwd_ok", 64'(ms_fwd_bus), {24'd0, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1});
    cyc;
    data_sram_data_ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1'b1, LD_W, 32'h0, 1'b1, 1'b1, 5'd2, 32'h48, 32'h7000);
    es_req_fire = 1'b1;
    cyc;
    es_to_ms_valid = 1'b0;
    es_req_fire = 1'b0;
    cyc;
    settle;
    check("rw_blk", 64'(ms_fwd_bus[39]), 64'd1);
    cyc;
    reset = 1'b1;
    cyc;
    reset = 1'b0;
    settle;
    check("rw_vld", 64'(ms_to_ws_valid), 64'd0);
    check("rw_allowin", 64'(ms_allowin), 64'd1);
    check("rw_fwd", 64'(ms_fwd_bus), 64'd0);
    check("rw_inflight", 64'(dut.r_inflight), 64'd0);
    check("rw_state", 64'({dut.r_valid, dut.r_buf_valid, dut.r_discard_cnt}), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
